// File: rtl/keypad_decoder.sv
// Keypad row decoder: synchronizes the row lines, debounces press and release
// against the scanner's active column, and emits one key code strobe per press.
module keypad_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columnas,
    input  logic [3:0] filas,
    output logic       scan_hold,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_filas_m;
    logic [3:0]       r_filas_s;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_row;
    logic [3:0]       r_col;
    logic             r_scan_hold;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    logic             w_row_ok;
    logic             w_col_ok;
    logic [1:0]       w_row_idx;
    logic [1:0]       w_col_idx;
    logic [3:0]       w_key_code;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    always_comb begin
        w_row_ok  = is_onehot(r_filas_s);
        w_col_ok  = is_onehot(columnas);
        w_row_idx = onehot_idx(r_row);
        w_col_idx = onehot_idx(r_col);
    end

    // Standard 4x4 telephone-style layout; '*' and '#' map to 0xE and 0xF.
    always_comb begin
        w_key_code = '0;
        case ({w_row_idx, w_col_idx})
            4'd0:  w_key_code = 4'h1;
            4'd1:  w_key_code = 4'h2;
            4'd2:  w_key_code = 4'h3;
            4'd3:  w_key_code = 4'hA;
            4'd4:  w_key_code = 4'h4;
            4'd5:  w_key_code = 4'h5;
            4'd6:  w_key_code = 4'h6;
            4'd7:  w_key_code = 4'hB;
            4'd8:  w_key_code = 4'h7;
            4'd9:  w_key_code = 4'h8;
            4'd10: w_key_code = 4'h9;
            4'd11: w_key_code = 4'hC;
            4'd12: w_key_code = 4'hE;
            4'd13: w_key_code = 4'h0;
            4'd14: w_key_code = 4'hF;
            default: w_key_code = 4'hD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filas_m   <= '0;
            r_filas_s   <= '0;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_scan_hold <= 1'b0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_filas_m   <= filas;
            r_filas_s   <= r_filas_m;
            r_key_valid <= 1'b0;
            // Outputs are updated on the transition edge so they track the next state.
            case (r_state)
                ST_IDLE: begin
                    r_scan_hold <= 1'b0;
                    r_key_held  <= 1'b0;
                    if (w_row_ok && w_col_ok) begin
                        r_row       <= r_filas_s;
                        r_col       <= columnas;
                        r_cnt       <= '0;
                        r_scan_hold <= 1'b1;
                        r_state     <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_filas_s != r_row) begin
                        r_cnt       <= '0;
                        r_scan_hold <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_cnt       <= '0;
                        r_key_code  <= w_key_code;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_state     <= ST_PRESSED;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (r_filas_s == 4'b0000) begin
                        r_cnt   <= '0;
                        r_state <= ST_RELEASE;
                    end
                end
                default: begin
                    if (r_filas_s != 4'b0000) begin
                        r_cnt   <= '0;
                        r_state <= ST_PRESSED;
                    end else if (r_cnt == CNT_MAX) begin
                        r_cnt       <= '0;
                        r_scan_hold <= 1'b0;
                        r_key_held  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign scan_hold = r_scan_hold;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder with DEBOUNCE_CYCLES=4.
module tb_keypad_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic       scan_hold;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_cmp;
    int n_err;

    typedef struct {
        logic       rst;
        logic [3:0] col;
        logic [3:0] row;
        logic       e_hold;
        logic       e_held;
        logic       e_valid;
        logic [3:0] e_code;
    } vec_t;

    vec_t vecs[$];

    keypad_decoder #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .columnas (columnas),
        .filas    (filas),
        .scan_hold(scan_hold),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (got running, required finished)");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] col, input logic [3:0] row,
                       input logic hold, input logic held, input logic valid,
                       input logic [3:0] code);
        vec_t v;
        v.rst = rst; v.col = col; v.row = row;
        v.e_hold = hold; v.e_held = held; v.e_valid = valid; v.e_code = code;
        vecs.push_back(v);
    endtask

    initial begin
        int cnt;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        columnas = 4'b0000;
        filas = 4'b0000;

        // Reset, then idle.
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 10; i++) add(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
        // Clean press of '8' (row 2, column 1): edge i counts from the first high sample.
        for (int i = 1; i <= 20; i++)
            add(1'b0, 4'b0010, 4'b0100, (i >= 3), (i >= 7), (i == 7), (i >= 7) ? 4'h8 : 4'h0);
        // Release: key_held and scan_hold drop after the 7th release edge.
        for (int i = 1; i <= 20; i++)
            add(1'b0, 4'b0010, 4'b0000, (i < 7), (i < 7), 1'b0, 4'h8);
        // Illegal patterns never leave IDLE.
        for (int i = 0; i < 6; i++) add(1'b0, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b0, 4'h8);
        for (int i = 0; i < 6; i++) add(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 4'h8);
        for (int i = 0; i < 6; i++) add(1'b0, 4'b0110, 4'b0001, 1'b0, 1'b0, 1'b0, 4'h8);
        for (int i = 0; i < 3; i++) add(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h8);

        foreach (vecs[k]) begin
            reset    = vecs[k].rst;
            columnas = vecs[k].col;
            filas    = vecs[k].row;
            tick();
            check($sformatf("vec%0d.scan_hold", k), {7'b0, scan_hold}, {7'b0, vecs[k].e_hold});
            check($sformatf("vec%0d.key_held", k),  {7'b0, key_held},  {7'b0, vecs[k].e_held});
            check($sformatf("vec%0d.key_valid", k), {7'b0, key_valid}, {7'b0, vecs[k].e_valid});
            check($sformatf("vec%0d.key_code", k),  {4'b0, key_code},  {4'b0, vecs[k].e_code});
        end

        // Press bounce on 'A' (row 0, column 3).
        columnas = 4'b1000;
        for (int i = 0; i < 12; i++) begin
            filas = ((i % 4) < 2) ? 4'b0001 : 4'b0000;
            tick();
            check($sformatf("bounce%0d.key_valid", i), {7'b0, key_valid}, 8'h0);
            check($sformatf("bounce%0d.key_held", i),  {7'b0, key_held},  8'h0);
        end
        filas = 4'b0001;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("stable%0d.key_valid", i), {7'b0, key_valid}, {7'b0, (i == 7)});
        end
        check("bounce.key_code", {4'b0, key_code}, 8'h0A);
        check("bounce.key_held", {7'b0, key_held}, 8'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bounce_post%0d.key_valid", i), {7'b0, key_valid}, 8'h0);
        end
        filas = 4'b0000;
        cnt = 0;
        while (key_held && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bounce.release_edges", 8'(cnt), 8'd7);
        tick();
        tick();

        // Release bounce after an accepted '#' (row 3, column 2).
        columnas = 4'b0100;
        filas = 4'b1000;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (key_valid) cnt++;
        end
        check("hash.valid_count", 8'(cnt), 8'd1);
        check("hash.key_code", {4'b0, key_code}, 8'h0F);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                filas = (i < 2) ? 4'b0000 : 4'b1000;
                tick();
                check($sformatf("relb%0d_%0d.key_held", r, i),  {7'b0, key_held},  8'h1);
                check($sformatf("relb%0d_%0d.scan_hold", r, i), {7'b0, scan_hold}, 8'h1);
                check($sformatf("relb%0d_%0d.key_valid", r, i), {7'b0, key_valid}, 8'h0);
            end
        end
        filas = 4'b0000;
        cnt = 0;
        while (key_held && cnt < 20) begin
            tick();
            cnt++;
        end
        check("hash.release_edges", 8'(cnt), 8'd7);
        check("hash.scan_hold_idle", {7'b0, scan_hold}, 8'h0);
        check("hash.code_kept", {4'b0, key_code}, 8'h0F);
        tick();
        tick();

        // Reset on edge 5 of a press of '1' aborts the debounce.
        columnas = 4'b0001;
        filas = 4'b0001;
        for (int i = 1; i <= 4; i++) tick();
        check("abort.scan_hold_debounce", {7'b0, scan_hold}, 8'h1);
        reset = 1'b1;
        filas = 4'b0000;
        tick();
        check("abort.scan_hold", {7'b0, scan_hold}, 8'h0);
        check("abort.key_held",  {7'b0, key_held},  8'h0);
        check("abort.key_valid", {7'b0, key_valid}, 8'h0);
        check("abort.key_code",  {4'b0, key_code},  8'h00);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (key_valid || scan_hold) cnt++;
        end
        check("abort.no_strobe", 8'(cnt), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
